// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath: sequencer steps and
// the control-field codes driven by the external control unit.
package mc_pkg;

    typedef enum logic [2:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } step_t;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_NOR = 4'hC;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RES_MDR  = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_PC4  = 2'd2;
    localparam logic [1:0] RES_ZERO = 2'd3;

    localparam logic [1:0] WA_RT   = 2'd0;
    localparam logic [1:0] WA_RD   = 2'd1;
    localparam logic [1:0] WA_RA   = 2'd2;
    localparam logic [1:0] WA_NONE = 2'd3;

endpackage

// File: rtl/regfile_p.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero, asynchronous clear of every register.
module regfile_p #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic                    we,
    input  logic [XLEN-1:0]         wd,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: one instruction per FETCH/DECODE/EXEC/[MEM]/WB
// sequence, with req/ack memory ports that tolerate wait states.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [31:0]     instruction,
    input  logic            sel_alu_b,
    input  logic            rf_we,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [1:0]      sel_pc,
    input  logic [1:0]      sel_result,
    input  logic [1:0]      sel_wa,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic [2:0]      step,
    output logic            retire
);

    localparam int AW = $clog2(NREG);

    step_t                  step_q;
    logic [XLEN-1:0]        pc_q;
    logic [31:0]            ir_p0;
    logic signed [XLEN-1:0] a_p1, b_p1, aluout_p2, mdr_p3;
    logic                   zero_p2;
    logic                   imem_req_q, dmem_req_q, dmem_we_q, retire_q;

    logic [XLEN-1:0]        rs_val, rt_val, pc_plus4, pc_next, wd;
    logic signed [XLEN-1:0] imm_sext, alu_b, alu_res;
    logic [4:0]             wa_full;

    function automatic logic signed [XLEN-1:0] alu_f(input logic [3:0] op,
                                                     input logic signed [XLEN-1:0] x,
                                                     input logic signed [XLEN-1:0] y);
        case (op)
            ALU_AND: alu_f = x & y;
            ALU_OR:  alu_f = x | y;
            ALU_ADD: alu_f = x + y;
            ALU_SUB: alu_f = x - y;
            ALU_SLT: alu_f = (x < y) ? XLEN'(1) : '0;
            ALU_NOR: alu_f = ~(x | y);
            default: alu_f = '0;
        endcase
    endfunction

    assign imm_sext = {{(XLEN-16){ir_p0[15]}}, ir_p0[15:0]};
    assign alu_b    = sel_alu_b ? imm_sext : b_p1;
    assign alu_res  = alu_f(alu_ctrl, a_p1, alu_b);
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        pc_next = pc_plus4;
        case (sel_pc)
            PC_BRANCH: pc_next = pc_plus4 + (imm_sext << 2);
            PC_JUMP:   pc_next = {pc_plus4[XLEN-1:28], ir_p0[25:0], 2'b00};
            PC_REG:    pc_next = a_p1;
            default:   pc_next = pc_plus4;
        endcase
    end

    // WA_NONE selects register 0, so the write is dropped by the regfile.
    always_comb begin
        wa_full = 5'd0;
        wd      = '0;
        case (sel_wa)
            WA_RT:   wa_full = ir_p0[20:16];
            WA_RD:   wa_full = ir_p0[15:11];
            WA_RA:   wa_full = 5'd31;
            default: wa_full = 5'd0;
        endcase
        case (sel_result)
            RES_MDR: wd = mdr_p3;
            RES_ALU: wd = aluout_p2;
            RES_PC4: wd = pc_plus4;
            default: wd = '0;
        endcase
    end

    regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clock (clock),
        .reset (reset),
        .ra1   (ir_p0[21 +: AW]),
        .ra2   (ir_p0[16 +: AW]),
        .wa    (wa_full[AW-1:0]),
        .we    (step_q == WB && rf_we),
        .wd    (wd),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q     <= RST;
            pc_q       <= RESET_PC;
            ir_p0      <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            aluout_p2  <= '0;
            zero_p2    <= 1'b0;
            mdr_p3     <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            case (step_q)
                RST: begin
                    imem_req_q <= 1'b1;
                    step_q     <= FETCH;
                end
                // FETCH -> DECODE: IR captured on the acknowledged cycle
                FETCH: if (imem_ack) begin
                    ir_p0      <= imem_rdata;
                    imem_req_q <= 1'b0;
                    step_q     <= DECODE;
                end
                // DECODE -> EXEC: operand latches
                DECODE: begin
                    a_p1   <= rs_val;
                    b_p1   <= rt_val;
                    step_q <= EXEC;
                end
                // EXEC -> MEM/WB: ALU result and zero flag latched together
                EXEC: begin
                    aluout_p2 <= alu_res;
                    zero_p2   <= (alu_res == '0);
                    if (mem_rd || mem_wr) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= mem_wr;
                        step_q     <= MEM;
                    end else begin
                        retire_q <= 1'b1;
                        step_q   <= WB;
                    end
                end
                // MEM -> WB: request held until ack, read data lands in MDR
                MEM: if (dmem_ack) begin
                    mdr_p3     <= dmem_rdata;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    retire_q   <= 1'b1;
                    step_q     <= WB;
                end
                // WB -> FETCH: PC commit
                WB: begin
                    pc_q       <= pc_next;
                    retire_q   <= 1'b0;
                    imem_req_q <= 1'b1;
                    step_q     <= FETCH;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    retire_q   <= 1'b0;
                    step_q     <= RST;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = aluout_p2;
    assign dmem_wdata  = b_p1;
    assign instruction = ir_p0;
    assign pc          = pc_q;
    assign alu_out     = aluout_p2;
    assign zero        = zero_p2;
    assign step        = step_q;
    assign retire      = retire_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Randomized bench for mc_datapath: the bench plays control unit and both
// memories, predicts each instruction architecturally and scores it at retire.
`timescale 1ns/1ps
module tb_mc_datapath;
    import mc_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [3:0] OPS [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'h9};

    logic clock = 1'b0, reset = 1'b1;
    logic imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [31:0] instruction, pc, alu_out;
    logic sel_alu_b = 0, rf_we = 0, mem_rd = 0, mem_wr = 0, zero, retire;
    logic [1:0] sel_pc = 0, sel_result = 0, sel_wa = 0;
    logic [3:0] alu_ctrl = 0;
    logic [2:0] step;

    mc_datapath #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .instruction(instruction),
        .sel_alu_b(sel_alu_b), .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .sel_pc(sel_pc), .sel_result(sel_result), .sel_wa(sel_wa), .alu_ctrl(alu_ctrl),
        .pc(pc), .alu_out(alu_out), .zero(zero), .step(step), .retire(retire)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event did not arrive in time", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "aborted");
    endtask

    typedef struct packed {
        logic alu_b, we, mrd, mwr;
        logic [1:0] spc, sres, swa;
        logic [3:0] op;
        logic cond;
    } ctl_t;

    typedef struct {
        logic [31:0] instr, fetch_pc, pc_next, aluout, daddr, dwdata;
        logic zero, dwe;
        int cycles, ireq, dreq;
    } exp_t;

    exp_t exp_q[$];

    // Architectural reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_mdr;

    function automatic ctl_t ctl(input logic alu_b, we, mrd, mwr, input logic [1:0] spc, sres, swa,
                                 input logic [3:0] op, input logic cond);
        ctl_t c;
        c.alu_b = alu_b; c.we = we; c.mrd = mrd; c.mwr = mwr;
        c.spc = spc; c.sres = sres; c.swa = swa; c.op = op; c.cond = cond;
        return c;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, y);
        case (op)
            4'h0: return x & y;
            4'h1: return x | y;
            4'h2: return x + y;
            4'h6: return x - y;
            4'h7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'hC: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc  = RESET_PC;
        m_mdr = '0;
    endtask

    task automatic issue(input logic [31:0] instr, input ctl_t c, input int iwait, dwait,
                         input logic [31:0] rdata, input bit hang);
        exp_t e;
        logic [31:0] a, b, imm, res, pc4, wd;
        logic [4:0] dst;
        logic [1:0] spc;
        bit mem;
        int n;
        n = 0;
        while (!imem_req && n < 100) begin @(negedge clock); n++; end
        if (!imem_req) abort_run("imem_req_wait");

        a   = m_regs[instr[25:21]];
        b   = m_regs[instr[20:16]];
        imm = {{16{instr[15]}}, instr[15:0]};
        res = ref_alu(c.op, a, c.alu_b ? imm : b);
        spc = c.cond ? ((res == 0) ? 2'd1 : 2'd0) : c.spc;
        mem = c.mrd | c.mwr;
        pc4 = m_pc + 32'd4;
        if (mem) m_mdr = rdata;
        case (c.sres)
            2'd0: wd = m_mdr;
            2'd1: wd = res;
            2'd2: wd = pc4;
            default: wd = 32'd0;
        endcase
        case (c.swa)
            2'd0: dst = instr[20:16];
            2'd1: dst = instr[15:11];
            2'd2: dst = 5'd31;
            default: dst = 5'd0;
        endcase
        e.instr = instr; e.fetch_pc = m_pc; e.aluout = res; e.zero = (res == 0);
        e.daddr = res; e.dwdata = b; e.dwe = c.mwr;
        e.cycles = 4 + iwait + (mem ? 1 + dwait : 0);
        e.ireq = iwait + 1;
        e.dreq = mem ? dwait + 1 : 0;
        case (spc)
            2'd0: e.pc_next = pc4;
            2'd1: e.pc_next = pc4 + (imm << 2);
            2'd2: e.pc_next = {pc4[31:28], instr[25:0], 2'b00};
            default: e.pc_next = a;
        endcase
        if (!hang) begin
            if (c.we && dst != 0) m_regs[dst] = wd;
            m_pc = e.pc_next;
            exp_q.push_back(e);
        end

        sel_alu_b = c.alu_b; rf_we = c.we; mem_rd = c.mrd; mem_wr = c.mwr;
        sel_pc = spc; sel_result = c.sres; sel_wa = c.swa; alu_ctrl = c.op;

        repeat (iwait) @(negedge clock);
        imem_ack = 1'b1; imem_rdata = instr;
        @(negedge clock);
        imem_rdata = $urandom;
        imem_ack = ($urandom_range(0, 3) == 0);
        if (imem_ack) begin @(negedge clock); imem_ack = 1'b0; end

        if (mem) begin
            n = 0;
            while (!dmem_req && n < 100) begin @(negedge clock); n++; end
            if (!dmem_req) abort_run("dmem_req_wait");
            repeat (dwait) @(negedge clock);
            if (hang) return;
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(negedge clock);
            dmem_rdata = $urandom;
            dmem_ack = ($urandom_range(0, 3) == 0);
            if (dmem_ack) begin @(negedge clock); dmem_ack = 1'b0; end
        end
    endtask

    task automatic addi(input logic [4:0] rt, rs, input logic [15:0] imm);
        issue({6'h08, rs, rt, imm}, ctl(1, 1, 0, 0, PC_SEQ, RES_ALU, WA_RT, ALU_ADD, 0), 0, 0, 0, 0);
    endtask

    task automatic rop(input logic [4:0] rd, rs, rt, input logic [3:0] op);
        issue({6'h00, rs, rt, rd, 11'h020}, ctl(0, 1, 0, 0, PC_SEQ, RES_ALU, WA_RD, op, 0), 0, 0, 0, 0);
    endtask

    task automatic jr(input logic [4:0] rs);
        issue({6'h00, rs, 15'h0, 6'h08}, ctl(0, 0, 0, 0, PC_REG, RES_ALU, WA_RD, ALU_ADD, 0), 0, 0, 0, 0);
    endtask

    task automatic rand_instr();
        ctl_t c;
        int k;
        k = $urandom_range(0, 7);
        c = ctl(0, 1, 0, 0, PC_SEQ, RES_ALU, WA_RD, OPS[$urandom_range(0, 7)], 0);
        case (k)
            1: begin c.sres = 2'($urandom_range(0, 3)); c.swa = 2'($urandom_range(0, 3)); end
            2: begin c.alu_b = 1; c.swa = WA_RT; end
            3: begin c.alu_b = 1; c.op = ALU_ADD; c.mrd = 1; c.sres = RES_MDR; c.swa = WA_RT; end
            4: begin c.alu_b = 1; c.op = ALU_ADD; c.mwr = 1; c.we = 0; end
            5: begin c.op = ALU_SUB; c.cond = 1; c.we = 0; end
            6: begin c.spc = PC_JUMP; c.we = 1'($urandom_range(0, 1)); c.sres = RES_PC4; c.swa = WA_RA; end
            7: begin c.spc = PC_REG; c.we = 0; end
            default: ;
        endcase
        issue($urandom, c, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 0);
    endtask

    // Monitor: per-instruction handshake bookkeeping, scored at each retire
    int cyc = 0, ireq_n = 0, dreq_n = 0;
    logic [31:0] iaddr0, daddr0, dwd0, next_pc;
    logic dwe0;
    bit chk_next = 0;

    always @(negedge clock) begin
        if (reset) begin
            cyc = 0; ireq_n = 0; dreq_n = 0; chk_next = 0;
        end else begin
            if (chk_next) begin
                chk("pc_next", pc, next_pc);
                chk_next = 0;
            end
            if (step != 3'd0) cyc++;
            if (imem_req) begin
                if (ireq_n == 0) iaddr0 = imem_addr;
                else chk("imem_addr_stable", imem_addr, iaddr0);
                ireq_n++;
            end
            if (dmem_req) begin
                if (dreq_n == 0) begin
                    daddr0 = dmem_addr; dwd0 = dmem_wdata; dwe0 = dmem_we;
                end else begin
                    chk("dmem_addr_stable", dmem_addr, daddr0);
                    chk("dmem_wdata_stable", dmem_wdata, dwd0);
                end
                dreq_n++;
            end
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("retire_pc", pc, e.fetch_pc);
                    chk("imem_addr", iaddr0, e.fetch_pc);
                    chk("instruction", instruction, e.instr);
                    chk("alu_out", alu_out, e.aluout);
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("latency", cyc, e.cycles);
                    chk("imem_req_cycles", ireq_n, e.ireq);
                    chk("dmem_req_cycles", dreq_n, e.dreq);
                    if (e.dreq > 0) begin
                        chk("dmem_addr", daddr0, e.daddr);
                        chk("dmem_wdata", dwd0, e.dwdata);
                        chk("dmem_we", 32'(dwe0), 32'(e.dwe));
                    end
                    next_pc = e.pc_next;
                    chk_next = 1;
                end
                cyc = 0; ireq_n = 0; dreq_n = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        abort_run("watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_ir", instruction, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        reset = 1'b0;

        addi(5'd8, 5'd0, 16'd3);
        issue(32'h2108_0005, ctl(1, 1, 0, 0, PC_SEQ, RES_ALU, WA_RT, ALU_ADD, 0), 0, 0, 0, 0);
        rop(5'd20, 5'd8, 5'd0, ALU_OR);

        issue({6'h23, 5'd0, 5'd5, 16'h0040}, ctl(1, 1, 1, 0, PC_SEQ, RES_MDR, WA_RT, ALU_ADD, 0),
              0, 3, 32'hDEAD_BEEF, 0);
        rop(5'd6, 5'd5, 5'd0, ALU_OR);

        addi(5'd1, 5'd0, 16'd7);
        addi(5'd2, 5'd0, 16'd7);
        addi(5'd3, 5'd0, 16'd8);
        addi(5'd9, 5'd0, 16'h0010);
        jr(5'd9);
        issue({6'h04, 5'd1, 5'd2, 16'hFFFF}, ctl(0, 0, 0, 0, PC_BRANCH, RES_ALU, WA_RT, ALU_SUB, 1), 0, 0, 0, 0);
        issue({6'h04, 5'd1, 5'd3, 16'hFFFF}, ctl(0, 0, 0, 0, PC_BRANCH, RES_ALU, WA_RT, ALU_SUB, 1), 0, 0, 0, 0);

        addi(5'd10, 5'd0, 16'h0100);
        jr(5'd10);
        issue({6'h03, 26'h010_0000}, ctl(0, 1, 0, 0, PC_JUMP, RES_PC4, WA_RA, ALU_ADD, 0), 0, 0, 0, 0);
        rop(5'd4, 5'd31, 5'd0, ALU_OR);
        issue({6'h00, 5'd1, 5'd2, 5'd7, 11'h020}, ctl(0, 1, 0, 0, PC_SEQ, RES_ALU, WA_NONE, ALU_ADD, 0), 0, 0, 0, 0);
        rop(5'd21, 5'd7, 5'd0, ALU_OR);

        addi(5'd12, 5'd0, 16'd1);
        addi(5'd11, 5'd0, 16'hFFFC);
        jr(5'd11);
        rop(5'd13, 5'd0, 5'd12, ALU_SUB);
        rop(5'd14, 5'd1, 5'd3, ALU_SLT);
        rop(5'd15, 5'd13, 5'd1, ALU_SLT);

        for (int i = 0; i < 150; i++) rand_instr();

        // Store abandoned by reset while the data memory is stalling
        addi(5'd8, 5'd0, 16'h1234);
        issue({6'h2b, 5'd8, 5'd8, 16'h0010}, ctl(1, 0, 0, 1, PC_SEQ, RES_ALU, WA_RT, ALU_ADD, 0), 0, 3, 0, 1);
        chk("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_dmem_req", 32'(dmem_req), 32'd0);
        chk("abort_dmem_we", 32'(dmem_we), 32'd0);
        chk("abort_step", 32'(step), 32'd0);
        chk("abort_pc", pc, RESET_PC);
        chk("abort_imem_req", 32'(imem_req), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rop(5'd1, 5'd8, 5'd31, ALU_OR);
        rop(5'd2, 5'd5, 5'd6, ALU_OR);
        rop(5'd3, 5'd20, 5'd13, ALU_OR);

        for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge clock);
        repeat (2) @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
